pipe_hazard_ctrl: RTL and testbench

- Central issue scheduler for the in-order pipeline. Decides each cycle whether the decode stage may hand its instruction to execute, or must stall, flush or freeze.
- Register values are read in decode with no forwarding. Read-after-write hazards are therefore resolved by a per-register pending-write scoreboard, cleared by writeback.
- Sits beside the decode stage: consumes decoded register indices, the execute-stage redirect and the memory busy signal; drives the stall and flush enables of the fetch, decode and execute registers.

---
 rtl/pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Issue scheduler beside decode: RAW scoreboard, stall/flush/freeze sequencing.
// Optional squash of the shadow instruction on redirect: define PIPE_CTRL_SPEC_SQUASH_EN.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int PEND_W       = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1_idx,
  input  logic             i_id_rs1_used,
  input  logic [4:0]       i_id_rs2_idx,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd_idx,
  input  logic             i_id_reg_write,
  input  logic             i_wb_write_enable,
  input  logic [4:0]       i_wb_write_idx,
  input  logic             i_ex_redirect,
  input  logic             i_mem_busy,
  output logic             o_issue,
  output logic             o_fetch_stall,
  output logic             o_decode_stall,
  output logic             o_decode_flush,
  output logic             o_execute_flush,
  output logic [1:0]       o_state_out,
  output logic             o_sb_error,
  output logic [CNT_W-1:0] o_hazard_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // state  | meaning
  // RUN    | issuing normally
  // STALL  | RAW hazard or full pending counter, bubble into execute
  // FLUSH  | post-redirect bubbles, r_flush_left cycles remain
  // FREEZE | memory busy, whole pipe held; r_resume holds the state to return to
  typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_FREEZE = 2'd3} state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t            r_state, r_resume;
  logic [FC_W-1:0]   r_flush_left;
  logic [PEND_W-1:0] r_pend [NUM_REGS];
  logic              r_sb_error;
  logic [CNT_W-1:0]  r_hazard_stall_cnt, r_flush_total;

  state_t            w_eff_state, w_next_state;
  logic [FC_W-1:0]   w_flush_left_next;
  logic [PEND_W-1:0] w_pend_next [NUM_REGS];
  logic              w_hazard, w_redirect_any, w_redirect_acc, w_stall_cyc, w_underflow;
  logic              w_squash;
  logic [4:0]        w_squash_rd;

  assign w_eff_state    = (r_state == S_FREEZE) ? r_resume : r_state;
  assign w_redirect_any = i_ex_redirect && !i_mem_busy;

  assign w_hazard = i_id_valid && (
      (i_id_rs1_used  && (i_id_rs1_idx != 5'd0) && (r_pend[i_id_rs1_idx] != '0)) ||
      (i_id_rs2_used  && (i_id_rs2_idx != 5'd0) && (r_pend[i_id_rs2_idx] != '0)) ||
      (i_id_reg_write && (i_id_rd_idx  != 5'd0) && (r_pend[i_id_rd_idx] == PEND_MAX)));

  always_comb begin
    o_issue           = 1'b0;
    o_fetch_stall     = 1'b0;
    o_decode_stall    = 1'b0;
    o_decode_flush    = 1'b0;
    w_next_state      = w_eff_state;
    w_flush_left_next = r_flush_left;
    w_redirect_acc    = 1'b0;
    w_stall_cyc       = 1'b0;
    if (i_mem_busy) begin
      o_fetch_stall  = 1'b1;
      o_decode_stall = 1'b1;
      w_next_state   = S_FREEZE;
    end else if (w_eff_state == S_FLUSH) begin
      o_decode_flush = 1'b1;
      if (w_redirect_any) begin
        w_flush_left_next = FC_W'(FLUSH_CYCLES - 1);
      end else if (r_flush_left <= FC_W'(1)) begin
        w_flush_left_next = '0;
        w_next_state      = S_RUN;
      end else begin
        w_flush_left_next = r_flush_left - FC_W'(1);
      end
    end else if (w_redirect_any) begin
      o_decode_flush = 1'b1;
      w_redirect_acc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_next_state      = S_FLUSH;
        w_flush_left_next = FC_W'(FLUSH_CYCLES - 1);
      end else begin
        w_next_state = S_RUN;
      end
    end else if (w_hazard) begin
      o_fetch_stall  = 1'b1;
      o_decode_stall = 1'b1;
      o_decode_flush = 1'b1;
      w_stall_cyc    = 1'b1;
      w_next_state   = S_STALL;
    end else begin
      o_issue      = i_id_valid;
      w_next_state = S_RUN;
    end
  end

`ifdef PIPE_CTRL_SPEC_SQUASH_EN
  logic       r_hist_valid;
  logic [4:0] r_hist_rd;

  // History is held while frozen so a redirect arriving after the freeze still sees its shadow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hist_valid <= 1'b0;
      r_hist_rd    <= 5'd0;
    end else if (!i_mem_busy) begin
      r_hist_valid <= o_issue && i_id_reg_write && (i_id_rd_idx != 5'd0);
      r_hist_rd    <= i_id_rd_idx;
    end
  end

  assign w_squash        = w_redirect_any && r_hist_valid;
  assign w_squash_rd     = r_hist_rd;
  assign o_execute_flush = w_redirect_any;
`else
  assign w_squash        = 1'b0;
  assign w_squash_rd     = 5'd0;
  assign o_execute_flush = 1'b0;
`endif

  always_comb begin
    int v;
    v           = 0;
    w_underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_pend_next[r] = '0;
      if (r != 0) begin
        v = int'(r_pend[r]);
        if (o_issue && i_id_reg_write && (i_id_rd_idx == 5'(r))) v = v + 1;
        if (i_wb_write_enable && (i_wb_write_idx == 5'(r)))       v = v - 1;
        if (w_squash && (w_squash_rd == 5'(r)))                    v = v - 1;
        if (v < 0) begin
          v           = 0;
          w_underflow = 1'b1;
        end else if (v > int'(PEND_MAX)) begin
          v = int'(PEND_MAX);
        end
        w_pend_next[r] = PEND_W'(v);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state            <= S_RUN;
      r_resume           <= S_RUN;
      r_flush_left       <= '0;
      r_sb_error         <= 1'b0;
      r_hazard_stall_cnt <= '0;
      r_flush_total      <= '0;
      for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
    end else begin
      r_state      <= w_next_state;
      r_flush_left <= w_flush_left_next;
      if (i_mem_busy) r_resume <= w_eff_state;
      for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= w_pend_next[r];
      if (w_underflow) r_sb_error <= 1'b1;
      if (w_stall_cyc && (r_hazard_stall_cnt != '1)) r_hazard_stall_cnt <= r_hazard_stall_cnt + 1'b1;
      if (w_redirect_acc && (r_flush_total != '1)) r_flush_total <= r_flush_total + 1'b1;
    end
  end

  assign o_state_out        = r_state;
  assign o_sb_error         = r_sb_error;
  assign o_hazard_stall_cnt = r_hazard_stall_cnt;
  assign o_flush_cnt        = r_flush_total;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected outputs go through a queue.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 16;
`ifdef PIPE_CTRL_SPEC_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic id_valid, rs1_used, rs2_used, reg_write, wb_en, redirect, busy;
  logic [4:0] rs1, rs2, rd, wb_idx;
  logic issue, fstall, dstall, dflush, xflush, sb_error;
  logic [1:0] state_out;
  logic [CNT_W-1:0] hz_cnt, fl_cnt;

  pipe_hazard_ctrl #(.NUM_REGS(32), .PEND_W(2), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_rs1_idx(rs1), .i_id_rs1_used(rs1_used),
    .i_id_rs2_idx(rs2), .i_id_rs2_used(rs2_used), .i_id_rd_idx(rd), .i_id_reg_write(reg_write),
    .i_wb_write_enable(wb_en), .i_wb_write_idx(wb_idx), .i_ex_redirect(redirect), .i_mem_busy(busy),
    .o_issue(issue), .o_fetch_stall(fstall), .o_decode_stall(dstall), .o_decode_flush(dflush),
    .o_execute_flush(xflush), .o_state_out(state_out), .o_sb_error(sb_error),
    .o_hazard_stall_cnt(hz_cnt), .o_flush_cnt(fl_cnt));

  typedef struct {
    string      tag;
    logic [4:0] outs;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] d, input logic w, input logic we,
                       input logic [4:0] wi, input logic rdr, input logic bz);
    id_valid = v;  rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2;
    rd = d; reg_write = w; wb_en = we; wb_idx = wi; redirect = rdr; busy = bz;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // e = {issue, fetch_stall, decode_stall, decode_flush}; st = state_out seen during this cycle
  task automatic step(input string tag, input logic [3:0] e, input logic [1:0] st);
    exp_t x;
    x.tag  = tag;
    x.outs = {e, SQ && redirect && !busy};
    x.st   = st;
    exp_q.push_back(x);
    @(negedge clk);
    x = exp_q.pop_front();
    check({x.tag, "/outs"}, 32'({issue, fstall, dstall, dflush, xflush}), 32'(x.outs));
    check({x.tag, "/state"}, 32'(state_out), 32'(x.st));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step("reset", 4'b0000, 2'd0);
    check("reset_sb_error", 32'(sb_error), 0);
    check("reset_hz_cnt", 32'(hz_cnt), 0);
    check("reset_fl_cnt", 32'(fl_cnt), 0);

    // RAW on x5, cleared by writeback with one cycle of latency
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);  step("issue_rd5", 4'b1000, 2'd0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("raw_stall", 4'b0111, 2'd0);
    drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);  step("raw_wb_same_cycle", 4'b0111, 2'd1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("raw_cleared", 4'b1000, 2'd1);

    // x0 is never tracked
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);  step("write_x0", 4'b1000, 2'd0);
    end
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);  step("read_x0", 4'b1000, 2'd0);

    // pending counter full on x7
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);  step("fill_rd7", 4'b1000, 2'd0);
    end
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);  step("full_stall", 4'b0111, 2'd0);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);  step("full_wb", 4'b0111, 2'd1);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);  step("full_issue", 4'b1000, 2'd1);
    check("hz_cnt_after_stalls", 32'(hz_cnt), 4);

    // redirect from RUN: two bubble cycles, instruction in decode is not issued
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);  step("redirect_run", 4'b0001, 2'd0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);  step("flush_cycle", 4'b0001, 2'd2);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);  step("after_flush", 4'b1000, 2'd0);
    check("fl_cnt_one", 32'(fl_cnt), 1);
    idle();                                  step("gap", 4'b0000, 2'd0);
    check("sb_error_clean", 32'(sb_error), 0);

    // freeze in FLUSH; writeback still retires x5; redirect while frozen ignored
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("redirect2", 4'b0001, 2'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1);  step("freeze_wb5", 4'b0110, 2'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  step("freeze_redirect", 4'b0110, 2'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("freeze_hold", 4'b0110, 2'd3);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("resume_flush", 4'b0001, 2'd3);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("read5_clear", 4'b1000, 2'd0);
    check("fl_cnt_two", 32'(fl_cnt), 2);

    // writeback to an idle register
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);  step("wb9_underflow", 4'b0000, 2'd0);
    check("sb_error_set", 32'(sb_error), 1);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("read9_no_stall", 4'b1000, 2'd0);
    check("sb_error_sticky", 32'(sb_error), 1);

    // redirect inside FLUSH reloads the bubble count without counting
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("redirect3", 4'b0001, 2'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("redirect_in_flush", 4'b0001, 2'd2);
    idle();                                  step("reloaded_flush", 4'b0001, 2'd2);
    idle();                                  step("back_to_run", 4'b0000, 2'd0);
    check("fl_cnt_three", 32'(fl_cnt), 3);
    check("hz_cnt_unchanged", 32'(hz_cnt), 4);

    // reset clears sticky error, counters and the full x7 scoreboard entry
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst2_sb_error", 32'(sb_error), 0);
    check("rst2_fl_cnt", 32'(fl_cnt), 0);
    check("rst2_hz_cnt", 32'(hz_cnt), 0);
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("read7_after_reset", 4'b1000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
